// File: rtl/grid_pkg.sv
// Shared grid geometry, object codes and scheduler state encoding.
package grid_pkg;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 12;
  localparam int CODE_W  = 3;
  localparam int COORD_W = 4;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);

  typedef enum logic [CODE_W-1:0] {
    OBJ_EMPTY  = 3'd0,
    OBJ_BODY   = 3'd1,
    OBJ_HEAD   = 3'd2,
    OBJ_APPLE  = 3'd3,
    OBJ_BORDER = 3'd4
  } obj_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Map lookup and display command handshake between scheduler and its peers.
interface frame_update_scheduler_if;
  import grid_pkg::*;

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [CODE_W-1:0]  obj_code;
  logic               cmd_valid;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;
  logic [CODE_W-1:0]  cmd_code;
  logic               cmd_done;

  modport master (
    output x, y, cmd_valid, cmd_x, cmd_y, cmd_code,
    input  obj_code, cmd_done
  );

  modport slave (
    input  x, y, cmd_valid, cmd_x, cmd_y, cmd_code,
    output obj_code, cmd_done
  );

endinterface

// File: rtl/grid_scan_counter.sv
// Raster x/y counter: x runs fastest, y steps when x wraps.
module grid_scan_counter
  import grid_pkg::*;
(
  input  logic               clk,
  input  logic               sync_reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;

  // Coordinate register: cleared outside a scan, stepped on advance.
  always_ff @(posedge clk) begin
    if (sync_reset || clear) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (advance) begin
      if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = (x_reg == X_LAST) && (y_reg == Y_LAST);

endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame diff scan of the game grid; issues draw commands only for cells
// whose code differs from what the display currently shows.
module frame_update_scheduler
  import grid_pkg::*;
(
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic                     frame_tick,
  input  logic                     game_over,
  frame_update_scheduler_if.master bus,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     init_cycle
);

  state_e             state_reg, state_next;
  logic               pend_reg;
  logic               full_reg;
  logic               init_cycle_reg;
  logic [COORD_W-1:0] cmd_x_reg, cmd_y_reg;
  logic [CODE_W-1:0]  cmd_code_reg;
  logic [CODE_W-1:0]  shadow_reg [GRID_H][GRID_W];

  logic               start, load, advance, shadow_we;
  logic [COORD_W-1:0] scan_x, scan_y;
  logic               scan_last;
  logic [CODE_W-1:0]  shadow_rd;

  grid_scan_counter u_scan (
    .clk        (clk),
    .sync_reset (sync_reset),
    .clear      ((state_reg == ST_IDLE) || (state_reg == ST_DONE)),
    .advance    (advance),
    .x          (scan_x),
    .y          (scan_y),
    .last       (scan_last)
  );

  assign shadow_rd = shadow_reg[scan_y][scan_x];

  // Next-state and control strobes for the scan/wait sequencer.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    shadow_we  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_tick || pend_reg) begin
          start      = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (full_reg || (bus.obj_code != shadow_rd)) begin
          load       = 1'b1;
          state_next = ST_WAIT;
        end else if (scan_last) begin
          state_next = ST_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.cmd_done) begin
          shadow_we = 1'b1;
          if (scan_last) begin
            state_next = ST_DONE;
          end else begin
            advance    = 1'b1;
            state_next = ST_SCAN;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, frame-mode flags and latched command.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_reg      <= ST_IDLE;
      pend_reg       <= 1'b0;
      full_reg       <= 1'b0;
      init_cycle_reg <= 1'b1;
      cmd_x_reg      <= '0;
      cmd_y_reg      <= '0;
      cmd_code_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // A tick arriving mid-frame is remembered once; extra ones are dropped.
      if (start)
        pend_reg <= 1'b0;
      else if (frame_tick && (state_reg != ST_IDLE))
        pend_reg <= 1'b1;
      if (start)
        full_reg <= init_cycle_reg | game_over;
      if (state_reg == ST_DONE)
        init_cycle_reg <= 1'b0;
      if (load) begin
        cmd_x_reg    <= scan_x;
        cmd_y_reg    <= scan_y;
        cmd_code_reg <= bus.obj_code;
      end
    end
  end

  // Shadow of on-screen codes, updated only when the driver acknowledges.
  always_ff @(posedge clk) begin
    for (int r = 0; r < GRID_H; r++) begin
      for (int c = 0; c < GRID_W; c++) begin
        if (sync_reset)
          shadow_reg[r][c] <= OBJ_EMPTY;
        else if (shadow_we && (cmd_y_reg == COORD_W'(r)) && (cmd_x_reg == COORD_W'(c)))
          shadow_reg[r][c] <= cmd_code_reg;
      end
    end
  end

  assign bus.x         = scan_x;
  assign bus.y         = scan_y;
  assign bus.cmd_valid = (state_reg == ST_WAIT);
  assign bus.cmd_x     = cmd_x_reg;
  assign bus.cmd_y     = cmd_y_reg;
  assign bus.cmd_code  = cmd_code_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign frame_done    = (state_reg == ST_DONE);
  assign init_cycle    = init_cycle_reg;

endmodule
